preamble_modulator: RTL and testbench
=====================================

// Module: preamble_modulator
// PURPOSE
//  Transmit-side counterpart of the RX correlator. Emits a programmable 128-chip
//  preamble as baseband I/Q samples on the TX sample strobe. Programmed through the
//  same cdata/cstate/cwrite port as the correlator, so one loaded code serves both
//  ends. Each chip is the conjugate of the correlator coefficient, so a sent frame
//  peaks the matched filter.
// PARAMETERS
//  SPC   1          samples per chip (1..16); each chip is held for SPC strobes
//  AMP   16'sd8192  chip amplitude, signed; emitted as +AMP / -AMP / 0
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous, active-high reset
//  txstrobe  in   1   one-cycle sample-rate strobe from the TX chain
//  start     in   1   one-cycle request to send one preamble
//  cdata     in   32  code word: [31:16] real bits, [15:0] imag bits
//  cstate    in   3   code word index 0..7
//  cwrite    in   1   write cdata into code word cstate
//  tx_i      out  16  signed I sample
//  tx_q      out  16  signed Q sample
//  tx_valid  out  1   one-cycle pulse: new tx_i/tx_q sample
//  busy      out  1   high from start acceptance until done
//  done      out  1   one-cycle pulse coincident with the last tx_valid
//  err       out  1   sticky: cwrite arrived while busy; cleared only by reset
//  debugbus  out  16  {busy, done, err, state[1:0], chip_cnt[6:0], samp_cnt[3:0]}
// BEHAVIOUR
//  - Reset (async): all outputs 0; code words 0; state IDLE; counters 0.
//  - Code store: 8 x 32-bit registers. In IDLE, cwrite writes word[cstate]<=cdata on
//    the clock edge. While busy, cwrite is dropped and err is set.
//  - Chip k (0..127): w=k[6:4], b=15-k[3:0]; (r,m)={word[w][16+b], word[w][b]}.
//  - Chip map (r,m): 00->(+AMP,0)  01->(0,-AMP)  10->(0,+AMP)  11->(-AMP,0).
//  - FSM states: IDLE, SEND, FLUSH.
//    IDLE: tx_i=tx_q=0. start -> SEND, busy<=1, chip_cnt=0, samp_cnt=0.
//      start in the same cycle as txstrobe is accepted. That strobe is not used;
//      chip 0 goes out on the next strobe.
//    SEND: on each txstrobe, register the chip_cnt sample into tx_i/tx_q and pulse
//      tx_valid the next cycle (latency 1 clk from strobe).
//      samp_cnt++; when samp_cnt==SPC-1: samp_cnt<=0 and chip_cnt++.
//      On the strobe for chip 127, samp SPC-1: done and the last tx_valid pulse
//      together; go to FLUSH.
//    FLUSH: one cycle; tx_i/tx_q<=0, busy<=0 -> IDLE.
//  - tx_i/tx_q hold their value between strobes; they are never X after reset.
//  - start while busy is ignored (no queueing, no err).
//  - Strobe gaps of any length are allowed. Back-to-back strobes every clk are supported.
//  - Frame length: exactly 128*SPC tx_valid pulses per start.
//  - Reset mid-frame: immediate async return to IDLE; outputs 0; code words cleared;
//    the frame is not resumed.
// TESTING
//  1 word0=32'hFFFF_0000, word1=32'h0000_FFFF, others 0, SPC=1; start;
//    strobe every clk -> chips 0-15=(0,+8192), 16-31=(0,-8192), 32-127=(+8192,0).
//    128 tx_valid; done on the 128th; busy low 1 clk later.
//  2 start and txstrobe in the same cycle -> no tx_valid for that strobe;
//    the first tx_valid follows the next strobe by 1 clk.
//  3 cwrite cstate=2 at chip 40 -> word2 unchanged (read back by a second frame);
//    err=1 and stays 1 until reset.
//  4 reset asserted at chip 40, between edges -> busy, tx_valid, tx_i, tx_q = 0 without
//    waiting for clk; later strobes produce no tx_valid.
//  5 SPC=4, strobe every 3rd clk, all code bits 1 -> 512 tx_valid, all (-8192,0);
//    each tx_valid exactly 1 clk after its strobe.
//  6 start again 1 clk after done -> accepted; second frame identical to the first.

Source files
------------

// File: rtl/preamble_modulator.sv
// Preamble modulator: emits a programmable 128-chip BPSK/QPSK-style preamble as
// baseband I/Q samples on the TX sample strobe. The code words use the same layout
// as the RX correlator, and each chip is the conjugate of the matching coefficient.
module preamble_modulator #(
    parameter int unsigned        SPC = 1,          // samples per chip, 1..16
    parameter logic signed [15:0] AMP = 16'sd8192   // chip amplitude
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               txstrobe,
    input  logic               start,
    input  logic [31:0]        cdata,
    input  logic [2:0]         cstate,
    input  logic               cwrite,
    output logic signed [15:0] tx_i,
    output logic signed [15:0] tx_q,
    output logic               tx_valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        debugbus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend  = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic [3:0]        SampLast = 4'(SPC - 1);
    localparam logic [6:0]        ChipLast = 7'd127;
    localparam logic signed [15:0] AmpNeg  = -AMP;

    state_e             state_q, state_d;
    logic [31:0]        code_q [8];
    logic [31:0]        code_d [8];
    logic [6:0]         chip_cnt_q, chip_cnt_d;
    logic [3:0]         samp_cnt_q, samp_cnt_d;
    logic signed [15:0] tx_i_q, tx_i_d;
    logic signed [15:0] tx_q_q, tx_q_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Current chip lookup: word = chip[6:4], bit = 15 - chip[3:0] (MSB first).
    logic [31:0]        cur_word;
    logic [3:0]         bit_idx;
    logic               chip_r;
    logic               chip_m;
    logic signed [15:0] chip_i;
    logic signed [15:0] chip_q;

    assign cur_word = code_q[chip_cnt_q[6:4]];
    assign bit_idx  = ~chip_cnt_q[3:0];
    // Real bit lives at 16+b, imaginary bit at b.
    assign chip_r   = cur_word[{1'b1, bit_idx}];
    assign chip_m   = cur_word[{1'b0, bit_idx}];

    // Map (real, imag) code bits to the conjugate constellation point.
    always_comb begin
        chip_i = '0;
        chip_q = '0;
        case ({chip_r, chip_m})
            2'b00:   begin chip_i = AMP;    chip_q = '0;     end
            2'b01:   begin chip_i = '0;     chip_q = AmpNeg; end
            2'b10:   begin chip_i = '0;     chip_q = AMP;    end
            default: begin chip_i = AmpNeg; chip_q = '0;     end
        endcase
    end

    // Next-state logic: code store writes, frame sequencing, sample generation.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        chip_cnt_d = chip_cnt_q;
        samp_cnt_d = samp_cnt_q;
        tx_i_d     = tx_i_q;
        tx_q_d     = tx_q_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            StIdle: begin
                tx_i_d = '0;
                tx_q_d = '0;
                if (cwrite) begin
                    code_d[cstate] = cdata;
                end
                // A strobe coinciding with start is deliberately not consumed.
                if (start) begin
                    state_d    = StSend;
                    chip_cnt_d = '0;
                    samp_cnt_d = '0;
                end
            end

            StSend: begin
                if (cwrite) begin
                    err_d = 1'b1;
                end
                if (txstrobe) begin
                    tx_i_d  = chip_i;
                    tx_q_d  = chip_q;
                    valid_d = 1'b1;
                    if (samp_cnt_q == SampLast) begin
                        samp_cnt_d = '0;
                        chip_cnt_d = chip_cnt_q + 7'd1;
                        if (chip_cnt_q == ChipLast) begin
                            done_d  = 1'b1;
                            state_d = StFlush;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end

            StFlush: begin
                // Still busy here, so code writes are rejected.
                if (cwrite) begin
                    err_d = 1'b1;
                end
                tx_i_d  = '0;
                tx_q_d  = '0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears the code store as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            code_q     <= '{default: '0};
            chip_cnt_q <= '0;
            samp_cnt_q <= '0;
            tx_i_q     <= '0;
            tx_q_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            chip_cnt_q <= chip_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            tx_i_q     <= tx_i_d;
            tx_q_q     <= tx_q_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign tx_i     = tx_i_q;
    assign tx_q     = tx_q_q;
    assign tx_valid = valid_q;
    assign done     = done_q;
    assign err      = err_q;
    assign debugbus = {busy, done_q, err_q, state_q, chip_cnt_q, samp_cnt_q};

endmodule

// File: tb/tb_preamble_modulator.sv
// Self-checking bench for preamble_modulator: two instances (SPC=1 and SPC=4) driven
// with randomized strobe gaps and code words, compared against a chip-table model.
module tb_preamble_modulator;

    localparam logic signed [15:0] AMP = 16'sd8192;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               txstrobe = 1'b0;
    logic               start1 = 1'b0;
    logic               start4 = 1'b0;
    logic               cwrite1 = 1'b0;
    logic               cwrite4 = 1'b0;
    logic [31:0]        cdata = '0;
    logic [2:0]         cstate = '0;

    logic signed [15:0] tx_i1, tx_q1, tx_i4, tx_q4;
    logic               tx_valid1, busy1, done1, err1;
    logic               tx_valid4, busy4, done4, err4;
    logic [15:0]        dbg1, dbg4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: code words and sticky error per instance.
    logic [31:0] mcode [2][8];
    bit          merr  [2];
    bit          sel = 1'b0;

    always #5 clk = ~clk;

    preamble_modulator #(.SPC(1), .AMP(AMP)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .txstrobe (txstrobe),
        .start    (start1),
        .cdata    (cdata),
        .cstate   (cstate),
        .cwrite   (cwrite1),
        .tx_i     (tx_i1),
        .tx_q     (tx_q1),
        .tx_valid (tx_valid1),
        .busy     (busy1),
        .done     (done1),
        .err      (err1),
        .debugbus (dbg1)
    );

    preamble_modulator #(.SPC(4), .AMP(AMP)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .txstrobe (txstrobe),
        .start    (start4),
        .cdata    (cdata),
        .cstate   (cstate),
        .cwrite   (cwrite4),
        .tx_i     (tx_i4),
        .tx_q     (tx_q4),
        .tx_valid (tx_valid4),
        .busy     (busy4),
        .done     (done4),
        .err      (err4),
        .debugbus (dbg4)
    );

    logic signed [15:0] o_i, o_q;
    logic               o_valid, o_busy, o_done, o_err;
    logic [15:0]        o_dbg;

    assign o_i     = sel ? tx_i4     : tx_i1;
    assign o_q     = sel ? tx_q4     : tx_q1;
    assign o_valid = sel ? tx_valid4 : tx_valid1;
    assign o_busy  = sel ? busy4     : busy1;
    assign o_done  = sel ? done4     : done1;
    assign o_err   = sel ? err4      : err1;
    assign o_dbg   = sel ? dbg4      : dbg1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (dut SPC=%0d, t=%0t)",
                     tag, got, exp, sel ? 4 : 1, $time);
        end
    endtask

    // Expected {I,Q} for sample s: chip k = s/spc, word k/16, bit 15-(k%16).
    function automatic logic [31:0] exp_iq(input int s, input int spc);
        int k, w, b;
        logic r, m;
        logic signed [15:0] pi, pq;
        k = s / spc;
        w = k / 16;
        b = 15 - (k % 16);
        r = mcode[sel][w][16 + b];
        m = mcode[sel][w][b];
        if (!r && !m) begin
            pi = AMP;  pq = 16'sd0;
        end else if (!r && m) begin
            pi = 16'sd0; pq = -AMP;
        end else if (r && !m) begin
            pi = 16'sd0; pq = AMP;
        end else begin
            pi = -AMP; pq = 16'sd0;
        end
        return {pi, pq};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            merr[i] = 1'b0;
            for (int w = 0; w < 8; w++) mcode[i][w] = '0;
        end
    endtask

    task automatic write_word(input bit which, input int idx, input logic [31:0] data);
        cstate = 3'(idx);
        cdata  = data;
        if (which) cwrite4 = 1'b1; else cwrite1 = 1'b1;
        @(negedge clk);
        cwrite1 = 1'b0;
        cwrite4 = 1'b0;
        mcode[which][idx] = data;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
        check({tag, "_busy"},  {31'b0, o_busy},  32'd0);
        check({tag, "_done"},  {31'b0, o_done},  32'd0);
        check({tag, "_iq"},    {o_i, o_q},       32'd0);
    endtask

    // Runs one frame; called and returns at a negedge. write_at/reset_at are sample
    // indices (-1 disables) for a busy-time code write or a mid-frame async reset.
    task automatic run_frame(input bit which, input int spc, input bit with_strobe,
                             input int gap_min, input int gap_max,
                             input int write_at, input int reset_at);
        int nsamp;
        int g;
        sel   = which;
        nsamp = 128 * spc;
        if (which) start4 = 1'b1; else start1 = 1'b1;
        txstrobe = with_strobe;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        txstrobe = 1'b0;
        check("accept_busy", {31'b0, o_busy}, 32'd1);
        check("start_strobe_unused", {31'b0, o_valid}, 32'd0);

        for (int s = 0; s < nsamp; s++) begin
            g = int'($urandom_range(gap_max, gap_min));
            if (s == write_at) begin
                cstate = 3'd2;
                cdata  = $urandom;
                if (which) cwrite4 = 1'b1; else cwrite1 = 1'b1;
                @(negedge clk);
                cwrite1 = 1'b0;
                cwrite4 = 1'b0;
                merr[which] = 1'b1;
                check("busy_write_err", {31'b0, o_err}, 32'd1);
                check("gap_no_valid", {31'b0, o_valid}, 32'd0);
            end
            for (int j = 0; j < g; j++) begin
                // Start while busy must be ignored.
                if ($urandom_range(7, 0) == 0) begin
                    if (which) start4 = 1'b1; else start1 = 1'b1;
                end
                @(negedge clk);
                start1 = 1'b0;
                start4 = 1'b0;
                check("gap_no_valid", {31'b0, o_valid}, 32'd0);
            end
            txstrobe = 1'b1;
            @(negedge clk);
            txstrobe = 1'b0;
            check("valid", {31'b0, o_valid}, 32'd1);
            check("iq", {o_i, o_q}, exp_iq(s, spc));
            check("done", {31'b0, o_done}, {31'b0, s == nsamp - 1});
            check("busy_in_frame", {31'b0, o_busy}, 32'd1);
            if (s != nsamp - 1) begin
                check("debug", {18'b0, o_dbg[15:13], o_dbg[10:0]},
                      {18'b0, 1'b1, 1'b0, merr[which], 7'((s + 1) / spc), 4'((s + 1) % spc)});
            end
            if (s == reset_at) begin
                #2 reset = 1'b1;
                #1;
                check_idle_outputs("async_reset");
                check("async_reset_err", {31'b0, o_err}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                clear_model();
                for (int j = 0; j < 10; j++) begin
                    txstrobe = 1'b1;
                    @(negedge clk);
                    txstrobe = 1'b0;
                    check("post_reset_no_valid", {31'b0, o_valid}, 32'd0);
                end
                return;
            end
        end

        @(negedge clk);
        check_idle_outputs("flush");
        check("err_sticky", {31'b0, o_err}, {31'b0, merr[which]});
    endtask

    initial begin
        clear_model();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #0;
            check_idle_outputs("reset");
            check("reset_err", {31'b0, o_err}, 32'd0);
            check("reset_debug", {16'b0, o_dbg}, 32'd0);
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Fixed code, strobe every clock, then an immediate second frame.
        write_word(1'b0, 0, 32'hFFFF_0000);
        write_word(1'b0, 1, 32'h0000_FFFF);
        run_frame(1'b0, 1, 1'b0, 0, 0, -1, -1);
        run_frame(1'b0, 1, 1'b0, 0, 0, -1, -1);

        // Random code; start with a coincident strobe; rejected write at chip 40.
        for (int w = 0; w < 8; w++) write_word(1'b0, w, $urandom);
        run_frame(1'b0, 1, 1'b1, 0, 3, 40, -1);
        run_frame(1'b0, 1, 1'b0, 0, 2, -1, -1);

        // Async reset at chip 40, then a frame from the cleared code store.
        run_frame(1'b0, 1, 1'b0, 0, 1, -1, 40);
        run_frame(1'b0, 1, 1'b0, 0, 1, -1, -1);

        // SPC=4: all code bits set, strobe every third clock.
        for (int w = 0; w < 8; w++) write_word(1'b1, w, 32'hFFFF_FFFF);
        run_frame(1'b1, 4, 1'b0, 2, 2, -1, -1);

        // SPC=4: random code, random gaps including back-to-back strobes.
        for (int w = 0; w < 8; w++) write_word(1'b1, w, $urandom);
        run_frame(1'b1, 4, 1'b1, 0, 2, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
